ls_queue_param: RTL
===================

Name: ls_queue_param

Overview:
- Parametrised in-order load/store queue; successor of the fixed 8-entry LS reservation station.
- Sits between rename/issue and the data-memory ports.
- Accepts one memory op per cycle and captures missing base/store-data operands from NUM_CDB result broadcast channels.
- Dispatches up to two oldest-first ops per cycle with computed address; adds flush, occupancy count, enqueue backpressure and same-cycle CDB bypass.

Parameters:
- DEPTH, 8, queue entries; power of two, >=4.
- DATA_W, 32, address/data width.
- TAG_W, 5, physical/ROB tag width.
- NUM_CDB, 4, number of result broadcast channels.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- flush  in  1  synchronous squash of all entries.
- enq  in  1  enqueue request.
- enq_ready  out  1  ~full; enq while full is ignored.
- enq_store  in  1  1 = store, 0 = load.
- enq_base_rdy, enq_data_rdy  in  1 each  operand already valid.
- enq_base, enq_data, enq_imm  in  DATA_W each  base value, store data, sign-extended offset.
- enq_base_tag, enq_data_tag  in  TAG_W each  producer tags for non-ready operands.
- enq_dest_tag  in  TAG_W  load destination tag / store ROB tag.
- cdb_valid  in  NUM_CDB  per-channel valid.
- cdb_tag  in  NUM_CDB*TAG_W  channel i at [i*TAG_W +: TAG_W].
- cdb_data  in  NUM_CDB*DATA_W  channel i at [i*DATA_W +: DATA_W].
- port_stall  in  2  bit j blocks dispatch slot j.
- d_valid  out  2  slot valid.
- d_store  out  2  slot is store.
- d_addr, d_data  out  2*DATA_W  slot j at [j*DATA_W +: DATA_W].
- d_tag  out  2*TAG_W  dest_tag of dispatched entry.
- count  out  $clog2(DEPTH+1)  occupied entries.
- full, empty  out  1 each  count==DEPTH / count==0.

Behaviour:
- Reset (rst=0, async): all entries invalid; head/tail=0; count=0; empty=1; full=0; enq_ready=1; every d_* output = 0.
- Outputs are registered. Dispatch decided in cycle N appears on d_* in cycle N+1. d_valid is held for exactly one cycle; all d_* return to 0 when not dispatching.
- Enqueue: accepted when enq && !full; written at tail; tail wraps mod DEPTH.
  - Loads ignore enq_data*; a load's data field is marked ready.
  - A non-ready operand whose tag matches a valid CDB channel in the same cycle is captured at enqueue (bypass).
- Capture: each cycle every valid entry with a non-ready operand compares its tag against all channels. On a match, value is written and operand marked ready. Multiple matching channels: lowest index wins.
- Eligibility: entry valid, base ready and (load or data ready), evaluated after this cycle's CDB capture. An entry enqueued this cycle is not eligible until the next cycle.
- Slot 0: head entry eligible && !port_stall[0] -> dispatch; addr = base + imm, modulo 2^DATA_W.
- Slot 1: requires slot 0 dispatching, head+1 (mod DEPTH) eligible, !port_stall[1], and full-width address of head+1 != address of head.
- Strict in-order: never dispatch head+1 without head.
- Dispatched entries are freed the same edge. count updates by +enq_accepted - dispatched, so a simultaneous enqueue and dispatch on a full queue is legal only for the dispatch: enq is still gated by full of the current cycle.
- Flush: highest priority over enq, capture and dispatch. Next edge: all entries invalid, head=tail=0, count=0, d_valid=0. Outputs registered in the flush cycle are cleared.
- Pointer wrap: head/tail are log2(DEPTH) bits with natural wrap; full/empty derive from count, never pointer equality.

Test Plan:
1. Reset, then enqueue load (base_rdy=1, base=0x100, imm=0x8, dest=3) -> next cycle d_valid=2'b01, d_addr[0]=0x108, d_tag[0]=3, d_store=0; count returns 0.
2. Store with base tag 7 and data tag 9 not ready; cdb ch2 tag 7 = 0x40, later ch0 tag 9 = 0xAA -> no dispatch until both captured; then d_store[0]=1, d_addr[0]=0x40+imm, d_data[0]=0xAA.
3. Two ready ops to addresses 0x200 and 0x204 -> both dispatch same cycle, d_valid=2'b11. Repeat with both at 0x200 -> first cycle 2'b01, second cycle 2'b01.
4. Fill DEPTH entries with head not ready -> full=1, enq_ready=0, extra enq dropped (count stays DEPTH). Broadcast head tag -> dispatch, and count wraps correctly over 2*DEPTH further ops.
5. port_stall=2'b01 with two ready ops -> nothing dispatched. port_stall=2'b10 -> only slot 0 dispatches.
6. Flush asserted with 5 entries and pending dispatch -> next cycle count=0, empty=1, d_valid=0. Async rst asserted mid-dispatch clears d_valid immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ls_queue_param.sv
// In-order load/store queue: captures missing operands from the CDB channels and
// dispatches up to two oldest ops per cycle with base+imm computed addresses.
module ls_queue_param #(
  parameter int DEPTH   = 8,
  parameter int DATA_W  = 32,
  parameter int TAG_W   = 5,
  parameter int NUM_CDB = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          enq,
  output logic                          enq_ready,
  input  logic                          enq_store,
  input  logic                          enq_base_rdy,
  input  logic                          enq_data_rdy,
  input  logic [DATA_W-1:0]             enq_base,
  input  logic [DATA_W-1:0]             enq_data,
  input  logic [DATA_W-1:0]             enq_imm,
  input  logic [TAG_W-1:0]              enq_base_tag,
  input  logic [TAG_W-1:0]              enq_data_tag,
  input  logic [TAG_W-1:0]              enq_dest_tag,
  input  logic [NUM_CDB-1:0]            cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0]      cdb_tag,
  input  logic [NUM_CDB*DATA_W-1:0]     cdb_data,
  input  logic [1:0]                    port_stall,
  output logic [1:0]                    d_valid,
  output logic [1:0]                    d_store,
  output logic [2*DATA_W-1:0]           d_addr,
  output logic [2*DATA_W-1:0]           d_data,
  output logic [2*TAG_W-1:0]            d_tag,
  output logic [$clog2(DEPTH+1)-1:0]    count,
  output logic                          full,
  output logic                          empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0]  valid_q, store_q, base_rdy_q, data_rdy_q;
  logic [DATA_W-1:0] base_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] imm_q [DEPTH];
  logic [TAG_W-1:0]  base_tag_q [DEPTH];
  logic [TAG_W-1:0]  data_tag_q [DEPTH];
  logic [TAG_W-1:0]  dest_q [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d, head1;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [DEPTH-1:0]  base_hit, data_hit, elig;
  logic [DATA_W-1:0] base_cap [DEPTH];
  logic [DATA_W-1:0] data_cap [DEPTH];
  logic              enq_base_hit, enq_data_hit, enq_acc;
  logic [DATA_W-1:0] enq_base_cap, enq_data_cap;
  logic              disp0, disp1;
  logic [DATA_W-1:0] addr0, addr1;

  logic [1:0]          d_valid_q, d_valid_d, d_store_q, d_store_d;
  logic [2*DATA_W-1:0] d_addr_q, d_addr_d, d_data_q, d_data_d;
  logic [2*TAG_W-1:0]  d_tag_q, d_tag_d;

  // Channels scanned high to low so the lowest matching index is the one that sticks.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      base_hit[i] = 1'b0;
      data_hit[i] = 1'b0;
      base_cap[i] = base_q[i];
      data_cap[i] = data_q[i];
      for (int c = NUM_CDB-1; c >= 0; c--) begin
        if (valid_q[i] && !base_rdy_q[i] && cdb_valid[c] &&
            cdb_tag[c*TAG_W +: TAG_W] == base_tag_q[i]) begin
          base_hit[i] = 1'b1;
          base_cap[i] = cdb_data[c*DATA_W +: DATA_W];
        end
        if (valid_q[i] && !data_rdy_q[i] && cdb_valid[c] &&
            cdb_tag[c*TAG_W +: TAG_W] == data_tag_q[i]) begin
          data_hit[i] = 1'b1;
          data_cap[i] = cdb_data[c*DATA_W +: DATA_W];
        end
      end
      elig[i] = valid_q[i] && (base_rdy_q[i] || base_hit[i]) &&
                (!store_q[i] || data_rdy_q[i] || data_hit[i]);
    end
  end

  always_comb begin
    enq_base_hit = 1'b0;
    enq_data_hit = 1'b0;
    enq_base_cap = enq_base;
    enq_data_cap = enq_data;
    for (int c = NUM_CDB-1; c >= 0; c--) begin
      if (!enq_base_rdy && cdb_valid[c] && cdb_tag[c*TAG_W +: TAG_W] == enq_base_tag) begin
        enq_base_hit = 1'b1;
        enq_base_cap = cdb_data[c*DATA_W +: DATA_W];
      end
      if (!enq_data_rdy && cdb_valid[c] && cdb_tag[c*TAG_W +: TAG_W] == enq_data_tag) begin
        enq_data_hit = 1'b1;
        enq_data_cap = cdb_data[c*DATA_W +: DATA_W];
      end
    end
  end

  // Handshake: an op is taken on a rising edge when enq && enq_ready (flush overrides);
  // dispatch has no ready input, port_stall[j] simply withholds slot j for that cycle.
  always_comb begin
    head1   = head_q + PTR_W'(1);
    addr0   = base_cap[head_q] + imm_q[head_q];
    addr1   = base_cap[head1] + imm_q[head1];
    disp0   = elig[head_q] && !port_stall[0];
    disp1   = disp0 && elig[head1] && !port_stall[1] && (addr1 != addr0);
    enq_acc = enq && !full && !flush;
    count_d = count_q + CNT_W'(enq_acc) - CNT_W'(disp0) - CNT_W'(disp1);
    head_d  = head_q + PTR_W'(disp0) + PTR_W'(disp1);
    tail_d  = tail_q + PTR_W'(enq_acc);
    d_valid_d = {disp1, disp0};
    d_store_d = {disp1 && store_q[head1], disp0 && store_q[head_q]};
    d_addr_d  = {disp1 ? addr1 : '0, disp0 ? addr0 : '0};
    d_data_d  = {disp1 ? data_cap[head1] : '0, disp0 ? data_cap[head_q] : '0};
    d_tag_d   = {disp1 ? dest_q[head1] : '0, disp0 ? dest_q[head_q] : '0};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q    <= '0;
      store_q    <= '0;
      base_rdy_q <= '0;
      data_rdy_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        base_q[i]     <= '0;
        data_q[i]     <= '0;
        imm_q[i]      <= '0;
        base_tag_q[i] <= '0;
        data_tag_q[i] <= '0;
        dest_q[i]     <= '0;
      end
    end else if (flush) begin
      valid_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (base_hit[i]) begin
          base_rdy_q[i] <= 1'b1;
          base_q[i]     <= base_cap[i];
        end
        if (data_hit[i]) begin
          data_rdy_q[i] <= 1'b1;
          data_q[i]     <= data_cap[i];
        end
      end
      if (disp0) valid_q[head_q] <= 1'b0;
      if (disp1) valid_q[head1] <= 1'b0;
      // The tail slot is never valid while an enqueue is accepted, so no conflict with the above.
      if (enq_acc) begin
        valid_q[tail_q]    <= 1'b1;
        store_q[tail_q]    <= enq_store;
        base_rdy_q[tail_q] <= enq_base_rdy || enq_base_hit;
        base_q[tail_q]     <= enq_base_cap;
        base_tag_q[tail_q] <= enq_base_tag;
        data_rdy_q[tail_q] <= !enq_store || enq_data_rdy || enq_data_hit;
        data_q[tail_q]     <= enq_store ? enq_data_cap : '0;
        data_tag_q[tail_q] <= enq_data_tag;
        imm_q[tail_q]      <= enq_imm;
        dest_q[tail_q]     <= enq_dest_tag;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst || flush) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      d_valid_q <= '0;
      d_store_q <= '0;
      d_addr_q  <= '0;
      d_data_q  <= '0;
      d_tag_q   <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      d_valid_q <= d_valid_d;
      d_store_q <= d_store_d;
      d_addr_q  <= d_addr_d;
      d_data_q  <= d_data_d;
      d_tag_q   <= d_tag_d;
    end
  end

  assign count     = count_q;
  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign enq_ready = !full;
  assign d_valid   = d_valid_q;
  assign d_store   = d_store_q;
  assign d_addr    = d_addr_q;
  assign d_data    = d_data_q;
  assign d_tag     = d_tag_q;
endmodule
